sign_extend: RTL and testbench

SIGN_EXTEND -- requirements
Module: sign_extend

---
 rtl/sign_extend_pkg.sv | 19 +
 rtl/ext_mux.sv | 55 +++++
 rtl/sign_extend.sv | 54 +++++
 tb/tb_sign_extend.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sign_extend_pkg.sv
// Shared mode encodings and default widths for the immediate sign/zero extender.
package sign_extend_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int IMM_W_DEF  = 16;
    localparam int MODE_W     = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_SEXT16  = 3'b000,
        MODE_ZEXT16  = 3'b001,
        MODE_SEXT8   = 3'b010,
        MODE_ZEXT8   = 3'b011,
        MODE_SEXT12  = 3'b100,
        MODE_UPPER16 = 3'b101,
        MODE_RSVD6   = 3'b110,
        MODE_RSVD7   = 3'b111
    } ext_mode_e;

endpackage

// File: rtl/ext_mux.sv
// Combinational mode decoder: selects an immediate field from the raw word and
// sign-extends, zero-extends or left-justifies it to the full data width.
module ext_mux
    import sign_extend_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMM_W  = IMM_W_DEF
) (
    input  logic        [DATA_W-1:0] in,
    input  logic        [MODE_W-1:0] mode,
    output logic signed [DATA_W-1:0] ext
);

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [IMM_W-1:0] v);
        return DATA_W'(v);
    endfunction

    function automatic logic signed [DATA_W-1:0] sext12(input logic signed [11:0] v);
        return DATA_W'(v);
    endfunction

    function automatic logic signed [DATA_W-1:0] sext8(input logic signed [7:0] v);
        return DATA_W'(v);
    endfunction

    function automatic logic signed [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] v);
        return {{(DATA_W-IMM_W){1'b0}}, v};
    endfunction

    function automatic logic signed [DATA_W-1:0] zext8(input logic [7:0] v);
        return {{(DATA_W-8){1'b0}}, v};
    endfunction

    function automatic logic signed [DATA_W-1:0] upper_imm(input logic [IMM_W-1:0] v);
        return {v, {(DATA_W-IMM_W){1'b0}}};
    endfunction

    // Bits above the primary immediate never contribute to any mode.
    logic unused_hi;
    assign unused_hi = ^in[DATA_W-1:IMM_W];

    always_comb begin
        ext = sext_imm(in[IMM_W-1:0]);
        case (mode)
            MODE_SEXT16:  ext = sext_imm(in[IMM_W-1:0]);
            MODE_ZEXT16:  ext = zext_imm(in[IMM_W-1:0]);
            MODE_SEXT8:   ext = sext8(in[7:0]);
            MODE_ZEXT8:   ext = zext8(in[7:0]);
            MODE_SEXT12:  ext = sext12(in[11:0]);
            MODE_UPPER16: ext = upper_imm(in[IMM_W-1:0]);
            default:      ext = sext_imm(in[IMM_W-1:0]);
        endcase
    end

endmodule

// File: rtl/sign_extend.sv
// Registered immediate extender: one-cycle latency, one result per cycle,
// with a valid strobe and a registered sign flag of the held result.
module sign_extend
    import sign_extend_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMM_W  = IMM_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in,
    input  logic              in_valid,
    input  logic [MODE_W-1:0] mode,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              out_neg
);

    // Stage p0: combinational extension of the incoming word
    logic signed [DATA_W-1:0] ext_p0;

    ext_mux #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_ext_mux (
        .in   (in),
        .mode (mode),
        .ext  (ext_p0)
    );

    // Stage p1: result register; data holds when no new word is accepted
    logic signed [DATA_W-1:0] out_p1;
    logic                     neg_p1;
    logic                     vld_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_p1 <= '0;
            neg_p1 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                out_p1 <= ext_p0;
                neg_p1 <= ext_p0[DATA_W-1];
            end
        end
    end

    assign out       = out_p1;
    assign out_neg   = neg_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_sign_extend.sv
// Directed self-checking bench for sign_extend.
module tb_sign_extend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in;
    logic        in_valid;
    logic [2:0]  mode;
    logic [31:0] out;
    logic        out_valid;
    logic        out_neg;

    int n_checks = 0;
    int n_fail   = 0;

    sign_extend dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .in_valid  (in_valid),
        .mode      (mode),
        .out       (out),
        .out_valid (out_valid),
        .out_neg   (out_neg)
    );

    always #5 clk = ~clk;

    // Present one input for one edge, then settle past the edge.
    task automatic drive(input logic [31:0] d, input logic [2:0] m, input logic v);
        in       = d;
        mode     = m;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(32'h1234_5678, 3'b000, 1'b1);
        drive(32'h0000_FFFF, 3'b000, 1'b0);
        n_checks++;
        if (out !== 32'h0) begin
            n_fail++; $display("FAIL reset_out: got %h expected %h", out, 32'h0);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (out_neg !== 1'b0) begin
            n_fail++; $display("FAIL reset_neg: got %b expected 0", out_neg);
        end
        rst_n = 1'b1;
        drive(32'h0, 3'b000, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_sext16;
        logic [31:0] vin [5];
        logic [31:0] vexp[5];
        logic [2:0]  vmode[5];
        vin[0] = 32'd2868;       vmode[0] = 3'b000; vexp[0] = 32'h0000_0B34;
        vin[1] = 32'h0000_FF51;  vmode[1] = 3'b000; vexp[1] = 32'hFFFF_FF51;
        vin[2] = 32'h0000_FFFF;  vmode[2] = 3'b000; vexp[2] = 32'hFFFF_FFFF;
        vin[3] = 32'd108;        vmode[3] = 3'b000; vexp[3] = 32'h0000_006C;
        vin[4] = 32'h0000_FF51;  vmode[4] = 3'b110; vexp[4] = 32'hFFFF_FF51;
        for (int i = 0; i < 5; i++) begin
            drive(vin[i], vmode[i], 1'b1);
            n_checks++;
            if (out !== vexp[i] || out_valid !== 1'b1 || out_neg !== vexp[i][31]) begin
                n_fail++;
                $display("FAIL sext16[%0d]: got out=%h vld=%b neg=%b expected out=%h vld=1 neg=%b",
                         i, out, out_valid, out_neg, vexp[i], vexp[i][31]);
            end
        end
    endtask

    task automatic test_upper_ignored;
        drive(32'hABCD_8000, 3'b000, 1'b1);
        n_checks++;
        if (out !== 32'hFFFF_8000 || out_neg !== 1'b1) begin
            n_fail++; $display("FAIL upper_ign_sext16: got %h neg=%b expected FFFF8000 neg=1", out, out_neg);
        end
        drive(32'hABCD_8000, 3'b001, 1'b1);
        n_checks++;
        if (out !== 32'h0000_8000 || out_neg !== 1'b0) begin
            n_fail++; $display("FAIL upper_ign_zext16: got %h neg=%b expected 00008000 neg=0", out, out_neg);
        end
    endtask

    task automatic test_other_modes;
        logic [2:0]  vmode[6];
        logic [31:0] vexp[6];
        vmode[0] = 3'b010; vexp[0] = 32'hFFFF_FF80;
        vmode[1] = 3'b011; vexp[1] = 32'h0000_0080;
        vmode[2] = 3'b100; vexp[2] = 32'hFFFF_FF80;
        vmode[3] = 3'b101; vexp[3] = 32'h0F80_0000;
        vmode[4] = 3'b111; vexp[4] = 32'h0000_0F80;
        vmode[5] = 3'b001; vexp[5] = 32'h0000_0F80;
        for (int i = 0; i < 6; i++) begin
            drive(32'h0000_0F80, vmode[i], 1'b1);
            n_checks++;
            if (out !== vexp[i] || out_valid !== 1'b1 || out_neg !== vexp[i][31]) begin
                n_fail++;
                $display("FAIL mode_%0b: got out=%h vld=%b neg=%b expected out=%h vld=1 neg=%b",
                         vmode[i], out, out_valid, out_neg, vexp[i], vexp[i][31]);
            end
        end
        // SEXT12 with bit 11 clear must stay positive.
        drive(32'h0000_F7FF, 3'b100, 1'b1);
        n_checks++;
        if (out !== 32'h0000_07FF || out_neg !== 1'b0) begin
            n_fail++; $display("FAIL sext12_pos: got %h neg=%b expected 000007FF neg=0", out, out_neg);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vin [4];
        logic [31:0] vexp[4];
        vin[0] = 32'h0000_0001; vexp[0] = 32'h0000_0001;
        vin[1] = 32'h0000_8001; vexp[1] = 32'hFFFF_8001;
        vin[2] = 32'h0000_7FFF; vexp[2] = 32'h0000_7FFF;
        vin[3] = 32'h0000_C000; vexp[3] = 32'hFFFF_C000;
        for (int i = 0; i < 4; i++) begin
            drive(vin[i], 3'b000, 1'b1);
            n_checks++;
            if (out !== vexp[i] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got out=%h vld=%b expected out=%h vld=1",
                         i, out, out_valid, vexp[i]);
            end
        end
        // Idle cycles: valid drops, result and flag hold even with new data on the bus.
        for (int i = 0; i < 2; i++) begin
            drive(32'h0000_0005, 3'b011, 1'b0);
            n_checks++;
            if (out_valid !== 1'b0 || out !== 32'hFFFF_C000 || out_neg !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: got out=%h vld=%b neg=%b expected out=FFFFC000 vld=0 neg=1",
                         i, out, out_valid, out_neg);
            end
        end
    endtask

    task automatic test_reset_priority;
        drive(32'h0000_1234, 3'b000, 1'b1);
        rst_n = 1'b0;
        drive(32'h0000_FFFF, 3'b000, 1'b1);
        n_checks++;
        if (out !== 32'h0 || out_valid !== 1'b0 || out_neg !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_priority: got out=%h vld=%b neg=%b expected out=0 vld=0 neg=0",
                     out, out_valid, out_neg);
        end
        rst_n = 1'b1;
        drive(32'h0000_FFFF, 3'b000, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || out !== 32'h0) begin
            n_fail++; $display("FAIL reset_cancel: got out=%h vld=%b expected out=0 vld=0", out, out_valid);
        end
        drive(32'h0000_FF80, 3'b010, 1'b1);
        n_checks++;
        if (out !== 32'hFFFF_FF80 || out_valid !== 1'b1 || out_neg !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset: got out=%h vld=%b neg=%b expected out=FFFFFF80 vld=1 neg=1",
                     out, out_valid, out_neg);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in       = '0;
        in_valid = 1'b0;
        mode     = '0;
        test_reset();
        test_sext16();
        test_upper_ignored();
        test_other_modes();
        test_back_to_back();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
